rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (we3/a3/wd3) between two sources:
//  in-order pipeline writeback (P) and a long-latency unit such as a divider or load miss (M).
//  A fixed-priority arbiter feeds one registered output stage.
//  A busy scoreboard tracks outstanding M destinations so the hazard unit can stall readers.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 30 +++
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

    typedef enum logic {SRC_P, SRC_M} wb_src_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for outstanding long-latency destinations.
// A set and a clear on the same register at the same edge leave the bit set.
module rf_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    output logic [NREG-1:0]   busy_o
);
    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Fixed-priority arbiter sharing the regfile write port between pipeline (P) and long-latency (M) writeback.
// Optional starvation guard for M is enabled by defining WB_STARVE_GUARD_EN.
import rf_pkg::*;

module rf_wb_arbiter #(
    parameter int XLEN     = rf_pkg::XLEN,
    parameter int NREG     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p_valid,
    input  logic [$clog2(NREG)-1:0] p_rd,
    input  logic [XLEN-1:0]         p_wd,
    output logic                    p_ready,
    input  logic                    m_valid,
    input  logic [$clog2(NREG)-1:0] m_rd,
    input  logic [XLEN-1:0]         m_wd,
    output logic                    m_ready,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                    we3,
    output logic [$clog2(NREG)-1:0] a3,
    output logic [XLEN-1:0]         wd3,
    output logic [NREG-1:0]         busy
);
    localparam int AW = $clog2(NREG);

    logic    guard_force;
    logic    p_xfer, m_xfer;
    wb_req_t p_req, m_req, sel_req;

    logic          we3_q, we3_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    wb_src_t       src_q, src_d;

    assign p_req   = '{rd: p_rd, wd: p_wd};
    assign m_req   = '{rd: m_rd, wd: m_wd};
    assign p_ready = !guard_force;
    assign m_ready = guard_force || !p_valid;
    assign p_xfer  = p_valid && p_ready;
    assign m_xfer  = m_valid && m_ready && !p_xfer;
    assign sel_req = p_xfer ? p_req : m_req;

`ifdef WB_STARVE_GUARD_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    assign guard_force = m_valid && (wait_cnt_q == WCW'(MAX_WAIT));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!m_valid || m_xfer) wait_cnt_d = '0;
        else                    wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end
`else
    assign guard_force = 1'b0;
`endif

    // a3/wd3 hold between transfers; only we3 drops
    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        src_d = src_q;
        if (p_xfer || m_xfer) begin
            we3_d = (sel_req.rd != '0);
            a3_d  = sel_req.rd;
            wd3_d = sel_req.wd;
            src_d = p_xfer ? SRC_P : SRC_M;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            src_q <= SRC_P;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            src_q <= src_d;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;

    rf_scoreboard #(.NREG(NREG), .REG_AW(AW)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_i     (iss_valid && (iss_rd != '0)),
        .set_idx_i (iss_rd),
        .clr_i     (we3_q && (src_q == SRC_M)),
        .clr_idx_i (a3_q),
        .busy_o    (busy)
    );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: reference model compared every cycle plus directed literal checks.
module tb_rf_wb_arbiter;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, m_valid, iss_valid;
    logic [4:0]  p_rd, m_rd, iss_rd;
    logic [31:0] p_wd, m_wd;
    logic        p_ready, m_ready, we3;
    logic [4:0]  a3;
    logic [31:0] wd3, busy;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    rf_wb_arbiter #(.XLEN(32), .NREG(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_rd(p_rd), .p_wd(p_wd), .p_ready(p_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_wd(m_wd), .m_ready(m_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the write that will land in the regfile, the set of
    // outstanding long-latency destinations, and how long M has been waiting.
    bit          mdl_we, mdl_from_m;
    logic [4:0]  mdl_a;
    logic [31:0] mdl_wd;
    bit [31:0]   mdl_busy;
    int          starve;

    initial begin
        mdl_we = 0; mdl_from_m = 0; mdl_a = 0; mdl_wd = 0; mdl_busy = 0; starve = 0;
    end

    always @(posedge clk) if (reset) chk_en = 1'b1;

    always @(negedge clk) begin
        bit f, pr, mr, pacc, macc, clearing;
        f    = GUARD && (starve == MAX_WAIT) && m_valid;
        pr   = !f;
        mr   = f || !p_valid;
        pacc = p_valid && pr;
        macc = m_valid && mr && !pacc;
        if (chk_en) begin
            check("p_ready", {31'b0, p_ready}, {31'b0, pr});
            check("m_ready", {31'b0, m_ready}, {31'b0, mr});
            check("we3",  {31'b0, we3}, {31'b0, mdl_we});
            check("a3",   {27'b0, a3},  {27'b0, mdl_a});
            check("wd3",  wd3,  mdl_wd);
            check("busy", busy, mdl_busy);
        end
        clearing = mdl_we && mdl_from_m;
        if (!reset && iss_valid && iss_rd != 0)
            assert (!mdl_busy[iss_rd] || (clearing && mdl_a == iss_rd))
                else $error("FAIL issue_to_busy: rd %0d already busy", iss_rd);
        if (reset) begin
            mdl_we = 0; mdl_from_m = 0; mdl_a = 0; mdl_wd = 0; mdl_busy = 0; starve = 0;
        end else begin
            if (clearing) mdl_busy[mdl_a] = 1'b0;
            if (iss_valid && iss_rd != 0) mdl_busy[iss_rd] = 1'b1;
            if (GUARD) starve = (!m_valid || macc) ? 0 : starve + 1;
            if (pacc) begin
                mdl_we = (p_rd != 0); mdl_a = p_rd; mdl_wd = p_wd; mdl_from_m = 0;
            end else if (macc) begin
                mdl_we = (m_rd != 0); mdl_a = m_rd; mdl_wd = m_wd; mdl_from_m = 1;
            end else begin
                mdl_we = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        p_valid = 0; m_valid = 0; iss_valid = 0;
    endtask

    initial begin
        reset = 1; p_valid = 1; p_rd = 5'd2; p_wd = 32'h1111_1111;
        m_valid = 1; m_rd = 5'd4; m_wd = 32'h2222_2222; iss_valid = 1; iss_rd = 5'd8;
        step(); step();
        check("rst_we3", {31'b0, we3}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wd3", wd3, 32'd0);
        reset = 0; idle();

        // P only
        p_valid = 1; p_rd = 5'd5; p_wd = 32'hDEAD_BEEF;
        #1 check("ponly_p_ready", {31'b0, p_ready}, 32'd1);
        step(); idle();
        check("ponly_we3", {31'b0, we3}, 32'd1);
        check("ponly_a3", {27'b0, a3}, 32'd5);
        check("ponly_wd3", wd3, 32'hDEAD_BEEF);

        // Collision: P wins, M follows when P drops
        p_valid = 1; p_rd = 5'd3; p_wd = 32'h33; m_valid = 1; m_rd = 5'd7; m_wd = 32'h77;
        #1 check("coll_p_ready", {31'b0, p_ready}, 32'd1);
        check("coll_m_ready", {31'b0, m_ready}, 32'd0);
        step(); p_valid = 0;
        #1 check("coll_m_ready2", {31'b0, m_ready}, 32'd1);
        check("coll_a3_p", {27'b0, a3}, 32'd3);
        step(); idle();
        check("coll_a3_m", {27'b0, a3}, 32'd7);
        check("coll_wd3_m", wd3, 32'h77);

        // x0 write from M
        m_valid = 1; m_rd = 5'd0; m_wd = 32'h1234;
        #1 check("x0_m_ready", {31'b0, m_ready}, 32'd1);
        step(); idle();
        check("x0_we3", {31'b0, we3}, 32'd0);
        check("x0_busy", busy, 32'd0);

        // Scoreboard set / clear / same-edge re-issue
        iss_valid = 1; iss_rd = 5'd9;
        step(); idle();
        check("sb_set", {31'b0, busy[9]}, 32'd1);
        m_valid = 1; m_rd = 5'd9; m_wd = 32'h99;
        step(); idle();
        check("sb_pending_we3", {31'b0, we3}, 32'd1);
        check("sb_still_busy", {31'b0, busy[9]}, 32'd1);
        iss_valid = 1; iss_rd = 5'd9;
        step(); idle();
        check("sb_set_wins", {31'b0, busy[9]}, 32'd1);
        m_valid = 1; m_rd = 5'd9; m_wd = 32'h9A;
        step(); idle();
        check("sb_before_clear", {31'b0, busy[9]}, 32'd1);
        step();
        check("sb_cleared", {31'b0, busy[9]}, 32'd0);

        // Starvation behaviour with P and M held valid
        p_valid = 1; p_rd = 5'd4; p_wd = 32'h44; m_valid = 1; m_rd = 5'd6; m_wd = 32'h66;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (GUARD && (i == 4 || i == 9)) begin
                check("guard_m_ready", {31'b0, m_ready}, 32'd1);
                check("guard_p_ready", {31'b0, p_ready}, 32'd0);
            end else begin
                check("starve_m_ready", {31'b0, m_ready}, 32'd0);
                check("starve_p_ready", {31'b0, p_ready}, 32'd1);
            end
            step();
            if (GUARD && i == 4) check("guard_a3_m", {27'b0, a3}, 32'd6);
        end
        idle();
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
